// File: rtl/i2s_dsp_slot_ctrl.sv
// Run/stop sequencer for the DSP/TDM WS generator on the sck domain.
// Tracks WS pulses into bit/slot position, slot enables, frame strobes and alignment errors.
module i2s_dsp_slot_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FCNT_W      = 16
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic [4:0]        cfg_num_bits_i,
  input  logic [2:0]        cfg_num_words_i,
  input  logic [7:0]        cfg_slot_mask_i,
  input  logic [15:0]       cfg_setup_time_i,
  input  logic              ws_i,
  output logic              ws_en_o,
  output logic [2:0]        slot_idx_o,
  output logic [4:0]        bit_idx_o,
  output logic              slot_active_o,
  output logic              word_done_o,
  output logic              frame_start_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic                en_s;
  logic [4:0]          bits_q;
  logic [2:0]          words_q;
  logic [7:0]          mask_q;
  logic [4:0]          bit_idx_q;
  logic [2:0]          slot_idx_q;
  logic                live_q;
  logic                err_q;
  logic [FCNT_W-1:0]   frame_cnt_q;
  logic [17:0]         tmo_q;
  logic [1:0]          gap_q;
  logic [5:0]          bits_p1;
  logic [3:0]          words_p1;
  logic [17:0]         tmo_load;
  logic                last_bit, frame_end;
  logic                start, timeout, ws_load, misaligned, missing;

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) en_sync_q <= '0;
    else         en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], cfg_en_i};
  end
  assign en_s = en_sync_q[SYNC_STAGES-1];

  assign bits_p1  = {1'b0, cfg_num_bits_i} + 6'd1;
  assign words_p1 = {1'b0, cfg_num_words_i} + 4'd1;
  assign tmo_load = 18'(cfg_setup_time_i) + 18'(bits_p1) * 18'(words_p1) + 18'd4;

  assign last_bit  = (bit_idx_q == bits_q);
  assign frame_end = live_q & last_bit & (slot_idx_q == words_q);

  // A WS on the frame-end cycle is the normal back-to-back start; anywhere else mid-frame it is a resync.
  assign misaligned = ws_i & live_q & ~frame_end;
  assign ws_load    = ws_i & (((state_q == S_SETUP) & en_s) | (state_q == S_RUN) |
                              ((state_q == S_DRAIN) & live_q & ~frame_end));
  assign missing    = (state_q == S_RUN) & ~live_q & (gap_q == 2'd2);

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_s) begin
          state_d = S_SETUP;
          start   = 1'b1;
        end
      end
      S_SETUP: begin
        if (!en_s)            state_d = S_IDLE;
        else if (ws_i)        state_d = S_RUN;
        else if (tmo_q <= 18'd1) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_RUN: begin
        if (!en_s) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!live_q || frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bits_q      <= '0;
      words_q     <= '0;
      mask_q      <= '0;
      bit_idx_q   <= '0;
      slot_idx_q  <= '0;
      live_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      if (start) begin
        bits_q  <= cfg_num_bits_i;
        words_q <= cfg_num_words_i;
        mask_q  <= cfg_slot_mask_i;
        tmo_q   <= tmo_load;
      end else if (state_q == S_SETUP) begin
        tmo_q <= tmo_q - 18'd1;
      end

      // Counters hold their last position between frames.
      if (ws_load) begin
        bit_idx_q  <= '0;
        slot_idx_q <= '0;
        live_q     <= 1'b1;
      end else if (live_q) begin
        if (frame_end) begin
          live_q <= 1'b0;
        end else if (last_bit) begin
          bit_idx_q  <= '0;
          slot_idx_q <= slot_idx_q + 3'd1;
        end else begin
          bit_idx_q <= bit_idx_q + 5'd1;
        end
      end

      if (start)          frame_cnt_q <= '0;
      else if (frame_end) frame_cnt_q <= frame_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};

      if (start)                                err_q <= 1'b0;
      else if (timeout || misaligned || missing) err_q <= 1'b1;

      if ((state_q == S_RUN) && !live_q) gap_q <= (gap_q == 2'd2) ? 2'd2 : gap_q + 2'd1;
      else                               gap_q <= '0;
    end
  end

  assign ws_en_o       = (state_q != S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;
  assign slot_idx_o    = slot_idx_q;
  assign bit_idx_o     = bit_idx_q;
  assign slot_active_o = live_q & mask_q[slot_idx_q];
  assign word_done_o   = slot_active_o & last_bit;
  assign frame_start_o = live_q & (bit_idx_q == 5'd0) & (slot_idx_q == 3'd0);
  assign frame_cnt_o   = frame_cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_i2s_dsp_slot_ctrl.sv
// Directed bench for i2s_dsp_slot_ctrl: start/stop, slot tracking, alignment, timeout and reset.
module tb_i2s_dsp_slot_ctrl;

  logic        sck_i = 1'b0;
  logic        rstn_i;
  logic        cfg_en_i;
  logic [4:0]  cfg_num_bits_i;
  logic [2:0]  cfg_num_words_i;
  logic [7:0]  cfg_slot_mask_i;
  logic [15:0] cfg_setup_time_i;
  logic        ws_i;
  logic        ws_en_o;
  logic [2:0]  slot_idx_o;
  logic [4:0]  bit_idx_o;
  logic        slot_active_o;
  logic        word_done_o;
  logic        frame_start_o;
  logic [15:0] frame_cnt_o;
  logic        busy_o;
  logic        err_o;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;
  int wd, act, fs;

  i2s_dsp_slot_ctrl #(.SYNC_STAGES(2), .FCNT_W(16)) dut (
    .sck_i(sck_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i),
    .cfg_num_bits_i(cfg_num_bits_i), .cfg_num_words_i(cfg_num_words_i),
    .cfg_slot_mask_i(cfg_slot_mask_i), .cfg_setup_time_i(cfg_setup_time_i),
    .ws_i(ws_i), .ws_en_o(ws_en_o), .slot_idx_o(slot_idx_o), .bit_idx_o(bit_idx_o),
    .slot_active_o(slot_active_o), .word_done_o(word_done_o), .frame_start_o(frame_start_o),
    .frame_cnt_o(frame_cnt_o), .busy_o(busy_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  always #5 sck_i = ~sck_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sck_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_ws();
    ws_i = 1'b1;
    tick(1);
    ws_i = 1'b0;
  endtask

  // Walks one frame from bit 0 of slot 0, counting strobes; optionally puts WS on the last bit.
  task automatic do_frame(input int total, input bit next_ws, output int n_wd, output int n_act, output int n_fs);
    n_wd = 0; n_act = 0; n_fs = 0;
    for (int i = 0; i < total; i++) begin
      n_wd  += int'(word_done_o);
      n_act += int'(slot_active_o);
      n_fs  += int'(frame_start_o);
      if (i == total - 1) ws_i = next_ws;
      tick(1);
      ws_i = 1'b0;
    end
  endtask

  task automatic set_cfg(input logic [4:0] b, input logic [2:0] w, input logic [7:0] m, input logic [15:0] s);
    cfg_num_bits_i   = b;
    cfg_num_words_i  = w;
    cfg_slot_mask_i  = m;
    cfg_setup_time_i = s;
  endtask

  initial begin
    rstn_i = 1'b0; cfg_en_i = 1'b0; ws_i = 1'b0;
    set_cfg(5'd0, 3'd0, 8'h00, 16'd0);
    tick(3);
    chk("rst_busy", busy_o, 0);
    chk("rst_ws_en", ws_en_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_fcnt", frame_cnt_o, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_active", slot_active_o, 0);

    // bits=15, words=1, mask=3: 32-cycle frames, back-to-back WS
    rstn_i = 1'b1;
    set_cfg(5'd15, 3'd1, 8'h03, 16'd100);
    cfg_en_i = 1'b1;
    tick(2);
    chk("sync_not_yet", busy_o, 0);
    tick(1);
    chk("setup_busy", busy_o, 1);
    chk("setup_ws_en", ws_en_o, 1);
    chk("setup_state", dbg_state_o, 1);
    pulse_ws();
    chk("a_run_state", dbg_state_o, 2);
    chk("a_fs_first", frame_start_o, 1);
    for (int f = 1; f <= 3; f++) begin
      do_frame(32, 1'b1, wd, act, fs);
      chk("a_wd_per_frame", wd, 2);
      chk("a_act_per_frame", act, 32);
      chk("a_fs_per_frame", fs, 1);
      chk("a_fcnt", frame_cnt_o, f);
    end
    chk("a_err", err_o, 0);

    // cfg change while running is ignored; en drop drains the current frame
    set_cfg(5'd7, 3'd3, 8'h05, 16'd100);
    cfg_en_i = 1'b0;
    do_frame(31, 1'b0, wd, act, fs);
    chk("a_old_cfg_act", act, 31);
    chk("a_old_cfg_wd", wd, 1);
    chk("a_drain_state", dbg_state_o, 3);
    chk("a_drain_ws_en", ws_en_o, 1);
    chk("a_last_wd", word_done_o, 1);
    tick(1);
    chk("a_idle_ws_en", ws_en_o, 0);
    chk("a_idle_busy", busy_o, 0);
    chk("a_fcnt_final", frame_cnt_o, 4);

    // bits=7, words=3, mask=5: only slots 0 and 2 active
    cfg_en_i = 1'b1;
    tick(3);
    chk("b_setup_state", dbg_state_o, 1);
    chk("b_fcnt_cleared", frame_cnt_o, 0);
    pulse_ws();
    for (int f = 1; f <= 2; f++) begin
      do_frame(32, 1'b1, wd, act, fs);
      chk("b_wd_per_frame", wd, 2);
      chk("b_act_per_frame", act, 16);
      chk("b_fcnt", frame_cnt_o, f);
    end
    do_frame(32, 1'b0, wd, act, fs);
    chk("b_fcnt_3", frame_cnt_o, 3);
    tick(2);
    chk("b_gap_two_ok", err_o, 0);
    tick(1);
    chk("b_gap_missing_err", err_o, 1);
    chk("b_hold_slot", slot_idx_o, 3);
    chk("b_hold_bit", bit_idx_o, 7);
    chk("b_still_run", dbg_state_o, 2);
    cfg_en_i = 1'b0;
    tick(3);
    chk("b_drain_gap", dbg_state_o, 3);
    tick(1);
    chk("b_idle", dbg_state_o, 0);
    chk("b_err_sticky", err_o, 1);

    // bits=15, words=3: misplaced WS then en drop at slot 1 bit 3
    set_cfg(5'd15, 3'd3, 8'h0F, 16'd100);
    cfg_en_i = 1'b1;
    tick(3);
    chk("c_err_cleared", err_o, 0);
    pulse_ws();
    tick(21);
    chk("c_pos_slot", slot_idx_o, 1);
    chk("c_pos_bit", bit_idx_o, 5);
    pulse_ws();
    chk("c_misalign_err", err_o, 1);
    chk("c_resync_slot", slot_idx_o, 0);
    chk("c_resync_bit", bit_idx_o, 0);
    chk("c_resync_fs", frame_start_o, 1);
    tick(19);
    chk("c_drop_slot", slot_idx_o, 1);
    chk("c_drop_bit", bit_idx_o, 3);
    cfg_en_i = 1'b0;
    tick(44);
    chk("c_last_ws_en", ws_en_o, 1);
    chk("c_last_slot", slot_idx_o, 3);
    chk("c_last_bit", bit_idx_o, 15);
    chk("c_last_state", dbg_state_o, 3);
    tick(1);
    chk("c_off_ws_en", ws_en_o, 0);
    chk("c_off_busy", busy_o, 0);
    chk("c_fcnt", frame_cnt_o, 1);

    // setup timeout: 10 + 8*1 + 4 = 22 cycles in SETUP
    set_cfg(5'd7, 3'd0, 8'h01, 16'd10);
    cfg_en_i = 1'b1;
    tick(3);
    chk("d_setup", dbg_state_o, 1);
    chk("d_err_cleared", err_o, 0);
    tick(21);
    chk("d_still_setup", dbg_state_o, 1);
    chk("d_no_err_yet", err_o, 0);
    tick(1);
    chk("d_timeout_idle", dbg_state_o, 0);
    chk("d_timeout_err", err_o, 1);
    tick(1);
    chk("d_restart_setup", dbg_state_o, 1);
    chk("d_restart_clear", err_o, 0);
    // en_s falling on the same edge as WS: IDLE wins
    cfg_en_i = 1'b0;
    tick(2);
    chk("d_pre_setup", dbg_state_o, 1);
    pulse_ws();
    chk("d_ws_ignored", dbg_state_o, 0);
    chk("d_no_fs", frame_start_o, 0);

    // asynchronous reset mid-frame
    set_cfg(5'd7, 3'd0, 8'h01, 16'd5);
    cfg_en_i = 1'b1;
    tick(3);
    pulse_ws();
    tick(3);
    chk("e_active", slot_active_o, 1);
    chk("e_bit", bit_idx_o, 3);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("e_async_busy", busy_o, 0);
    chk("e_async_ws_en", ws_en_o, 0);
    chk("e_async_active", slot_active_o, 0);
    chk("e_async_bit", bit_idx_o, 0);
    tick(2);
    rstn_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
